deinterleaver: RTL

//  802.11a receiver PLCP DATA block deinterleaver: inverse of the transmit interleaver's first permutation.

---
 rtl/deinterleaver_if.sv | 21 ++
 rtl/deinterleaver.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/deinterleaver_if.sv
// Bit-serial stream bundle between the demapper, the deinterleaver and the Viterbi decoder.
// The master drives coded bits in; the slave returns them in original coded order.
interface deinterleaver_if;
  logic       Clear;
  logic       InBit;
  logic       InValid;
  logic       OutBit;
  logic       OutValid;
  logic       OutLast;
  logic [7:0] SymCount;

  modport master (
    output Clear, InBit, InValid,
    input  OutBit, OutValid, OutLast, SymCount
  );

  modport slave (
    input  Clear, InBit, InValid,
    output OutBit, OutValid, OutLast, SymCount
  );
endinterface

// File: rtl/deinterleaver.sv
// 802.11a PLCP DATA deinterleaver: ping-pong banks, written in received order j,
// read back in coded order k through row/column address counters.
module deinterleaver #(
  parameter int N_CBPS = 48,
  parameter int N_COLS = 16
) (
  input logic            Clock,
  input logic            Reset,
  deinterleaver_if.slave bus
);

  localparam int N_ROWS = N_CBPS / N_COLS;
  localparam int AW     = $clog2(N_CBPS);

  typedef enum logic {IDLE, READ} state_t;

  logic [N_CBPS-1:0] mem_q [2];
  logic [N_CBPS-1:0] mem_d [2];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic              wbank_q, wbank_d;
  logic              sym_done;

  state_t            state_q, state_d;
  logic              rbank_q, rbank_d;
  logic [3:0]        col_q, col_d;
  logic [2:0]        row_q, row_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              last_k;

  logic              out_bit_q, out_bit_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [7:0]        sym_count_q, sym_count_d;

  always_comb begin
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    wbank_d  = wbank_q;
    sym_done = 1'b0;
    if (bus.Clear) begin
      wptr_d = '0;
    end else if (bus.InValid) begin
      mem_d[wbank_q][wptr_q] = bus.InBit;
      if (wptr_q == AW'(N_CBPS - 1)) begin
        wptr_d   = '0;
        wbank_d  = ~wbank_q;
        sym_done = 1'b1;
      end else begin
        wptr_d = wptr_q + AW'(1);
      end
    end
  end

  // Launch emits k=0 (always j=0) on the completing edge itself, so the
  // counters then point at k=1: column 1, row 0, address N_ROWS.
  always_comb begin
    state_d     = state_q;
    rbank_d     = rbank_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    sym_count_d = sym_count_q;
    last_k      = (col_q == 4'(N_COLS - 1)) && (row_q == 3'(N_ROWS - 1));
    if (bus.Clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sym_done) begin
            state_d     = READ;
            rbank_d     = wbank_q;
            out_bit_d   = mem_q[wbank_q][0];
            out_valid_d = 1'b1;
            col_d       = 4'd1;
            row_d       = 3'd0;
            addr_d      = AW'(N_ROWS);
          end
        end
        READ: begin
          out_bit_d   = mem_q[rbank_q][addr_q];
          out_valid_d = 1'b1;
          if (last_k) begin
            out_last_d  = 1'b1;
            sym_count_d = sym_count_q + 8'd1;
            state_d     = IDLE;
            if (sym_done) begin
              state_d = READ;
              rbank_d = wbank_q;
              col_d   = 4'd0;
              row_d   = 3'd0;
              addr_d  = '0;
            end
          end else if (col_q == 4'(N_COLS - 1)) begin
            col_d  = 4'd0;
            row_d  = row_q + 3'd1;
            addr_d = AW'(row_q) + AW'(1);
          end else begin
            col_d  = col_q + 4'd1;
            addr_d = addr_q + AW'(N_ROWS);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wptr_q      <= '0;
      wbank_q     <= 1'b0;
      state_q     <= IDLE;
      rbank_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sym_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      wbank_q     <= wbank_d;
      state_q     <= state_d;
      rbank_q     <= rbank_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign bus.OutBit   = out_bit_q;
  assign bus.OutValid = out_valid_q;
  assign bus.OutLast  = out_last_q;
  assign bus.SymCount = sym_count_q;

endmodule
